uart_rx_ovs: RTL and testbench
==============================

# uart_rx_ovs

Oversampling UART receiver: the far-end partner of the existing UART transmitter, for links where `rx` comes from an external, unsynchronised source rather than an on-chip loopback. It recovers 8-bit frames using 16x oversampling with a baud rate chosen by `selection`, matching the baud generator, and supports optional parity. Each byte is presented on a held valid/ack handshake, with framing, parity and overrun status.

## Interface
- `DIV0`, default 326: `ipclk` cycles per oversample tick when `selection`=0.
- `DIV1`, default 163: cycles per tick when `selection`=1.
- `DIV2`, default 82: cycles per tick when `selection`=2.
- `DIV3`, default 27: cycles per tick when `selection`=3. All `DIVn` ≥ 2.
- `ipclk` input 1: the single clock; all logic on the rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `rx` input 1: serial line, asynchronous; idles high.
- `selection` input 2: baud select.
- `parity_en` input 1: a parity bit follows the data bits.
- `parity_odd` input 1: 1 = odd parity, 0 = even parity.
- `data` output 8: last received byte.
- `readyop` output 1: byte valid; held until acknowledged.
- `ack` input 1: consumer accepts the byte.
- `frame_err` output 1: stop bit sampled low (belongs to the current byte).
- `parity_err` output 1: parity mismatch (belongs to the current byte).
- `overrun` output 1: sticky; a byte was dropped.

## Operation
- **Synchroniser:** 2-flop on `rx`, reset to 1. All decisions use the synchronised `rx_s`.
- **Tick generator:**
  - Counter runs 0..DIVsel−1; `tick` pulses one cycle at the terminal count.
  - `selection`, `parity_en` and `parity_odd` are latched only in IDLE. Changes mid-frame take effect at the next frame.
- **Bit timing:**
  - Sample counter runs 0..15 per bit, advancing on `tick`.
  - `rx_s` is sampled at counts 7, 8 and 9; the bit value is the 2-of-3 majority, decided at count 9.
- **States:** IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: on a tick with `rx_s`=0 → START with sample count 0. The tick counter free-runs, so start detection is quantised to one tick.
  - START: majority 1 at count 9 → IDLE (glitch rejected, no output). Majority 0 → at count 15 → DATA, bit index 0.
  - DATA: 8 bits, LSB first, shifted in at count 9. After bit 7 at count 15 → PARITY if `parity_en`, else STOP.
  - PARITY: bit sampled at count 9. Error if the XOR of the 8 data bits and the parity bit ≠ `parity_odd`. At count 15 → STOP.
  - STOP: decided at count 9.
    - Majority 1 → IDLE.
    - Majority 0 → `frame_err`=1 and → WAIT_HIGH. WAIT_HIGH → IDLE on the first tick with `rx_s`=1 (break / stuck-low tolerant).
- **Delivery (at the STOP decision point):**
  - `readyop`=0: `data`, `frame_err` and `parity_err` are loaded together, and `readyop` is set. `parity_err` is 0 when parity is disabled.
  - `readyop`=1: `data`, `frame_err` and `parity_err` are kept, the new byte is discarded, and `overrun` is set.
- **Handshake:**
  - `ack` while `readyop`=1 clears `readyop` next cycle; `data` and the error flags keep their values.
  - `ack` while `readyop`=0 is ignored.
  - If `ack` and a delivery fall in the same cycle, the delivery wins: new byte loaded, `readyop` stays 1, no overrun.
  - `overrun` clears only on reset.
- **Reset (asynchronous, any time, including mid-frame):**
  - State → IDLE; all counters → 0; synchroniser → 1.
  - `data`=8'h00, `readyop`=0, `frame_err`=0, `parity_err`=0, `overrun`=0.
  - A partial frame is discarded. After release, reception begins at the next low `rx_s`.

## Timing
- Bit period = 16 × DIVsel cycles.
- Synchroniser adds 2 cycles of latency.
- Delivery (`readyop` rising) follows the start-bit falling edge by (16·(9+P) + 9)·DIVsel cycles, ± one tick of start quantisation, + 2 cycles (P = 1 if parity is enabled).
- Returning to IDLE at mid-stop gives half a bit of margin for the next start bit, so back-to-back frames are received without loss.
- `readyop` rises one cycle after the decision tick. It falls one cycle after `ack`.

## Test plan
- **Basic byte:** DIV1=2, sel=1, no parity. Send 0xA5 with 1 stop bit → `readyop`=1, `data`=0xA5, both error flags 0. `ack` → `readyop`=0 next cycle.
- **Parity:** even parity, send 0x5A with parity bit 0 → no error. Repeat with parity bit 1 → `parity_err`=1, `data`=0x5A. Odd parity with 0x01 and parity bit 0 → no error.
- **Framing and break:** send 0x3C with stop bit 0 → `frame_err`=1. Hold `rx` low for 40 bit periods → no further `readyop`. Raise `rx`, send 0x11 → `data`=0x11, `frame_err`=0.
- **Glitch rejection:** `rx` low for 3 ticks then high → `readyop` stays 0 and the state returns to IDLE.
- **Overrun and back-to-back:** send 0x12 then 0x34 back-to-back without `ack` → `data`=0x12, `overrun`=1. Next, send 0x56 with `ack` asserted in the delivery cycle → `data`=0x56, `readyop`=1.
- **Reset mid-frame:** pull `rstn` low during bit 4 → all outputs return to reset values immediately. After release, send 0xC3 → `data`=0xC3.

Source files
------------

// File: rtl/uart_rx_ovs_if.sv
// Byte delivery bus of the oversampling UART receiver: held valid with ack, plus per-byte status.
interface uart_rx_ovs_if;
    logic [7:0] data;
    logic       readyop;
    logic       ack;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    modport master (
        output data,
        output readyop,
        output frame_err,
        output parity_err,
        output overrun,
        input  ack
    );

    modport slave (
        input  data,
        input  readyop,
        input  frame_err,
        input  parity_err,
        input  overrun,
        output ack
    );
endinterface

// File: rtl/uart_rx_ovs.sv
// 16x oversampling UART receiver: 2-flop synchroniser, selectable tick divider,
// 2-of-3 mid-bit voting, optional parity, and a held valid/ack byte output.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | line idle; config tracks inputs; a low tick starts a frame
// START     | qualifying the start bit; a high vote rejects it as a glitch
// DATA      | shifting in 8 data bits, LSB first
// PARITY    | sampling the parity bit and recording a mismatch
// STOP      | voting the stop bit; delivers the byte at mid-stop
// WAIT_HIGH | stop bit was low; hold off until the line returns high
module uart_rx_ovs #(
    parameter int DIV0 = 326,
    parameter int DIV1 = 163,
    parameter int DIV2 = 82,
    parameter int DIV3 = 27
) (
    input  logic          ipclk,
    input  logic          rstn,
    input  logic          rx,
    input  logic [1:0]    selection,
    input  logic          parity_en,
    input  logic          parity_odd,
    uart_rx_ovs_if.master rx_if
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    state_t      state_q, state_d;

    logic        rx_meta_q, rx_s_q;
    logic [1:0]  sel_q;
    logic        par_en_q, par_odd_q;

    logic [15:0] tick_cnt_q, tick_cnt_d;
    logic [15:0] div_m1;
    logic        tick;

    logic [3:0]  samp_q, samp_d;
    logic        s7_q, s7_d, s8_q, s8_d;
    logic        maj, mid, last;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_bad_q, par_bad_d;
    logic        deliver, stop_low;

    logic [7:0]  data_q, data_d;
    logic        readyop_q, readyop_d;
    logic        frame_err_q, frame_err_d;
    logic        parity_err_q, parity_err_d;
    logic        overrun_q, overrun_d;

    always_ff @(posedge ipclk or negedge rstn) begin
        if (!rstn) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Configuration only follows the inputs between frames.
    always_ff @(posedge ipclk or negedge rstn) begin
        if (!rstn) begin
            sel_q     <= 2'd0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
        end else if (state_q == IDLE) begin
            sel_q     <= selection;
            par_en_q  <= parity_en;
            par_odd_q <= parity_odd;
        end
    end

    always_comb begin
        case (sel_q)
            2'd0:    div_m1 = 16'(DIV0 - 1);
            2'd1:    div_m1 = 16'(DIV1 - 1);
            2'd2:    div_m1 = 16'(DIV2 - 1);
            default: div_m1 = 16'(DIV3 - 1);
        endcase
        // >= keeps the counter bounded if a smaller divisor is selected mid-count.
        tick       = (tick_cnt_q >= div_m1);
        tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;
    end

    always_ff @(posedge ipclk or negedge rstn) begin
        if (!rstn) tick_cnt_q <= 16'd0;
        else       tick_cnt_q <= tick_cnt_d;
    end

    assign maj  = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);
    assign mid  = tick && (samp_q == 4'd9);
    assign last = tick && (samp_q == 4'd15);

    always_comb begin
        state_d   = state_q;
        samp_d    = samp_q;
        s7_d      = s7_q;
        s8_d      = s8_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        deliver   = 1'b0;
        stop_low  = 1'b0;

        if (tick && state_q != IDLE) begin
            samp_d = samp_q + 4'd1;
            if (samp_q == 4'd7) s7_d = rx_s_q;
            if (samp_q == 4'd8) s8_d = rx_s_q;
        end

        case (state_q)
            IDLE: begin
                samp_d = 4'd0;
                if (tick && !rx_s_q) begin
                    state_d   = START;
                    par_bad_d = 1'b0;
                end
            end
            START: begin
                if (mid && maj) begin
                    state_d = IDLE;
                end else if (last) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                end
            end
            DATA: begin
                if (mid) shift_d = {maj, shift_q[7:1]};
                if (last) begin
                    if (bit_idx_q == 3'd7) state_d = par_en_q ? PARITY : STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            PARITY: begin
                if (mid)  par_bad_d = ((^shift_q) ^ maj) != par_odd_q;
                if (last) state_d = STOP;
            end
            STOP: begin
                // Leaving at mid-stop leaves half a bit to catch a back-to-back start.
                if (mid) begin
                    deliver  = 1'b1;
                    stop_low = !maj;
                    state_d  = maj ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (tick && rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ipclk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            samp_q    <= 4'd0;
            s7_q      <= 1'b1;
            s8_q      <= 1'b1;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            par_bad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            samp_q    <= samp_d;
            s7_q      <= s7_d;
            s8_q      <= s8_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_bad_q <= par_bad_d;
        end
    end

    // A delivery coinciding with ack replaces the byte instead of overrunning.
    always_comb begin
        data_d       = data_q;
        readyop_d    = readyop_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = overrun_q;
        if (deliver) begin
            if (!readyop_q || rx_if.ack) begin
                data_d       = shift_q;
                frame_err_d  = stop_low;
                parity_err_d = par_bad_q;
                readyop_d    = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (readyop_q && rx_if.ack) begin
            readyop_d = 1'b0;
        end
    end

    always_ff @(posedge ipclk or negedge rstn) begin
        if (!rstn) begin
            data_q       <= 8'h00;
            readyop_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            data_q       <= data_d;
            readyop_q    <= readyop_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_if.data       = data_q;
    assign rx_if.readyop    = readyop_q;
    assign rx_if.frame_err  = frame_err_q;
    assign rx_if.parity_err = parity_err_q;
    assign rx_if.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Scenario bench for uart_rx_ovs: frames are driven bit by bit at 16*DIV1 cycles per bit,
// expected bytes are queued as each frame is sent and popped when readyop reports it.
module tb_uart_rx_ovs;

    localparam int D1  = 2;
    localparam int BIT = 16 * D1;

    logic       ipclk = 1'b0;
    logic       rstn  = 1'b0;
    logic       rx    = 1'b1;
    logic [1:0] selection  = 2'd1;
    logic       parity_en  = 1'b0;
    logic       parity_odd = 1'b0;

    uart_rx_ovs_if bus ();

    uart_rx_ovs #(.DIV0(4), .DIV1(D1), .DIV2(3), .DIV3(5)) dut (
        .ipclk      (ipclk),
        .rstn       (rstn),
        .rx         (rx),
        .selection  (selection),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .rx_if      (bus)
    );

    always #5 ipclk = ~ipclk;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic drive_bit(input logic b);
        @(negedge ipclk);
        rx = b;
        repeat (BIT - 1) @(negedge ipclk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                              input logic stopv, input bit push);
        exp_t e;
        if (push) begin
            e.d  = d;
            e.fe = ~stopv;
            e.pe = pen ? (((^d) ^ pbit) != parity_odd) : 1'b0;
            exp_q.push_back(e);
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (pen) drive_bit(pbit);
        drive_bit(stopv);
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.readyop === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge ipclk);
        end
    endtask

    task automatic check_delivery(input string name);
        exp_t e;
        bit   ok;
        wait_ready(4 * BIT, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s readyop: got %b want 1 (timeout)", name, bus.readyop);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s scoreboard: got empty queue want an expected byte", name);
        end else begin
            e = exp_q.pop_front();
            if (bus.data !== e.d) begin
                n_fail++;
                $display("FAIL %s data: got %h want %h", name, bus.data, e.d);
            end
            n_checks++;
            if (bus.frame_err !== e.fe) begin
                n_fail++;
                $display("FAIL %s frame_err: got %b want %b", name, bus.frame_err, e.fe);
            end
            n_checks++;
            if (bus.parity_err !== e.pe) begin
                n_fail++;
                $display("FAIL %s parity_err: got %b want %b", name, bus.parity_err, e.pe);
            end
        end
    endtask

    task automatic do_ack(input string name);
        logic [7:0] held;
        held = bus.data;
        @(negedge ipclk);
        bus.ack = 1'b1;
        @(negedge ipclk);
        bus.ack = 1'b0;
        n_checks++;
        if (bus.readyop !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ack readyop: got %b want 0", name, bus.readyop);
        end
        n_checks++;
        if (bus.data !== held) begin
            n_fail++;
            $display("FAIL %s ack data kept: got %h want %h", name, bus.data, held);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if ({bus.data, bus.readyop, bus.frame_err, bus.parity_err, bus.overrun} !== 12'h000) begin
            n_fail++;
            $display("FAIL %s outputs: got data=%h rdy=%b fe=%b pe=%b ovr=%b want all 0",
                     name, bus.data, bus.readyop, bus.frame_err, bus.parity_err, bus.overrun);
        end
    endtask

    task automatic test_reset();
        bus.ack = 1'b0;
        rstn = 1'b0;
        repeat (3) @(negedge ipclk);
        check_reset_outputs("reset");
        rstn = 1'b1;
        repeat (BIT) @(negedge ipclk);
        n_checks++;
        if (bus.readyop !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset readyop: got %b want 0", bus.readyop);
        end
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1);
        check_delivery("basic_a5");
        do_ack("basic_a5");
    endtask

    task automatic test_parity();
        @(negedge ipclk);
        parity_en  = 1'b1;
        parity_odd = 1'b0;
        repeat (4) @(negedge ipclk);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 1'b1);
        check_delivery("even_ok");
        do_ack("even_ok");
        send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 1'b1);
        check_delivery("even_bad");
        do_ack("even_bad");
        parity_odd = 1'b1;
        repeat (4) @(negedge ipclk);
        send_frame(8'h01, 1'b1, 1'b0, 1'b1, 1'b1);
        check_delivery("odd_ok");
        do_ack("odd_ok");
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        repeat (4) @(negedge ipclk);
    endtask

    task automatic test_framing_break();
        int spurious;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        check_delivery("frame_err");
        do_ack("frame_err");
        spurious = 0;
        rx = 1'b0;
        repeat (40 * BIT) begin
            @(negedge ipclk);
            if (bus.readyop !== 1'b0) spurious++;
        end
        n_checks++;
        if (spurious != 0) begin
            n_fail++;
            $display("FAIL break readyop: got %0d cycles high want 0", spurious);
        end
        rx = 1'b1;
        repeat (2 * BIT) @(negedge ipclk);
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b1);
        check_delivery("after_break");
        do_ack("after_break");
    endtask

    task automatic test_glitch();
        @(negedge ipclk);
        rx = 1'b0;
        repeat (3 * D1) @(negedge ipclk);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge ipclk);
        n_checks++;
        if (bus.readyop !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch readyop: got %b want 0", bus.readyop);
        end
        n_checks++;
        if (dut.state_q !== 3'd0) begin
            n_fail++;
            $display("FAIL glitch state: got %0d want 0 (IDLE)", dut.state_q);
        end
        send_frame(8'h69, 1'b0, 1'b0, 1'b1, 1'b1);
        check_delivery("after_glitch");
        do_ack("after_glitch");
    endtask

    task automatic test_ack_collision();
        bit hit;
        send_frame(8'h77, 1'b0, 1'b0, 1'b1, 1'b1);
        check_delivery("pending_77");
        hit = 1'b0;
        fork
            send_frame(8'h56, 1'b0, 1'b0, 1'b1, 1'b1);
            begin
                for (int i = 0; i < 14 * BIT; i++) begin
                    @(negedge ipclk);
                    if (dut.deliver === 1'b1) begin
                        bus.ack = 1'b1;
                        @(negedge ipclk);
                        bus.ack = 1'b0;
                        hit = 1'b1;
                        break;
                    end
                end
            end
        join
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL collision delivery: got no delivery want one (timeout)");
        end
        check_delivery("collision_56");
        n_checks++;
        if (bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL collision overrun: got %b want 0", bus.overrun);
        end
        do_ack("collision_56");
    endtask

    task automatic test_back_to_back();
        send_frame(8'h12, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(8'h34, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (BIT) @(negedge ipclk);
        check_delivery("overrun_12");
        n_checks++;
        if (bus.overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun flag: got %b want 1", bus.overrun);
        end
    endtask

    task automatic test_reset_mid_frame();
        fork
            send_frame(8'h99, 1'b0, 1'b0, 1'b1, 1'b0);
            begin
                repeat (5 * BIT + BIT / 2) @(negedge ipclk);
                rstn = 1'b0;
                #1;
                check_reset_outputs("reset_mid_frame");
            end
        join
        repeat (4) @(negedge ipclk);
        rstn = 1'b1;
        repeat (BIT) @(negedge ipclk);
        n_checks++;
        if (bus.readyop !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_discarded readyop: got %b want 0", bus.readyop);
        end
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b1);
        check_delivery("after_reset_c3");
        do_ack("after_reset_c3");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_framing_break();
        test_glitch();
        test_ack_collision();
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
